// File: rtl/exp_adc_pkg.sv
// Shared definitions for the experiment-ADC SPI link, used by both the
// responder and the ADC-side master.
package exp_adc_pkg;

  typedef enum logic {
    MODE_CNV = 1'b0,
    MODE_REG = 1'b1
  } adc_mode_e;

  localparam logic [23:0] EXIT_WORD        = 24'h801401;
  localparam logic [2:0]  REG_ENTRY_PREFIX = 3'b101;
  localparam int unsigned REG_FRAME_LEN    = 24;
  localparam int unsigned EDGE_CNT_MAX     = 63;

  function automatic int unsigned conv_frame_len(input int unsigned num_sdi);
    return 32 / num_sdi;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one SPI pin plus a third stage for edge detect.
// level, rise and fall are mutually aligned.
module spi_pin_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= {3{ResetVal}};
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], pin};
      rise   <= sync_q[1] & ~sync_q[2];
      fall   <= ~sync_q[1] & sync_q[2];
    end
  end

  assign level = sync_q[2];

endmodule

// File: rtl/axis_exp_adc_responder.sv
// SPI responder emulating the multi-lane experiment ADC: serves conversion
// samples from s_axis and forwards 24-bit register frames on m_axis.
module axis_exp_adc_responder
  import exp_adc_pkg::*;
#(
  parameter int unsigned NUM_SDI  = 4,
  parameter logic [23:0] ExitWord = EXIT_WORD
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               spi_csn,
  input  logic               spi_sck,
  input  logic               spi_sdo,
  output logic [NUM_SDI-1:0] spi_sdi,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               reg_mode,
  output logic [7:0]         underrun_count,
  output logic               frame_error
);

  typedef enum logic {IDLE, ACTIVE} frame_state_e;

  localparam logic [5:0] ConvLen = 6'(conv_frame_len(NUM_SDI));
  localparam logic [5:0] RegLen  = 6'(REG_FRAME_LEN);
  localparam logic [5:0] EdgeMax = 6'(EDGE_CNT_MAX);

  logic csn_level, csn_rise, csn_fall;
  logic sck_level, sck_rise, sck_fall;
  logic sdo_level, sdo_rise, sdo_fall;
  logic unused_ok;

  frame_state_e state_q, state_d;
  adc_mode_e    mode_q, mode_d;
  logic         frame_start, frame_end;
  logic         reg_frame, conv_frame, bad_frame, out_busy, drop_word, s_hs;
  logic         ready_en_q, hold_valid_q, hold_snap_q;
  logic [31:0]  hold_data_q, shift_q;
  logic [5:0]   edge_cnt_q;
  logic [23:0]  capture_q;

  spi_pin_sync #(.ResetVal(1'b1)) u_csn_sync (
    .aclk(aclk), .aresetn(aresetn), .pin(spi_csn),
    .level(csn_level), .rise(csn_rise), .fall(csn_fall)
  );
  spi_pin_sync #(.ResetVal(1'b0)) u_sck_sync (
    .aclk(aclk), .aresetn(aresetn), .pin(spi_sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );
  spi_pin_sync #(.ResetVal(1'b0)) u_sdo_sync (
    .aclk(aclk), .aresetn(aresetn), .pin(spi_sdo),
    .level(sdo_level), .rise(sdo_rise), .fall(sdo_fall)
  );

  assign unused_ok = &{1'b0, sck_level, sdo_rise, sdo_fall};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    unique case (state_q)
      IDLE: if (csn_fall) begin
        state_d     = ACTIVE;
        frame_start = 1'b1;
      end
      ACTIVE: if (csn_rise) begin
        state_d   = IDLE;
        frame_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign reg_frame  = frame_end && (edge_cnt_q == RegLen);
  assign conv_frame = frame_end && (edge_cnt_q == ConvLen) && (mode_q == MODE_CNV);
  assign bad_frame  = frame_end && !reg_frame && !conv_frame;
  // A word leaving on m_axis this very cycle frees the slot for the new one.
  assign out_busy   = m_axis_tvalid && !m_axis_tready;
  assign drop_word  = reg_frame && out_busy;
  assign s_hs       = s_axis_tvalid && s_axis_tready;

  always_comb begin
    mode_d = mode_q;
    if (reg_frame) begin
      if (capture_q[23:21] == REG_ENTRY_PREFIX)                 mode_d = MODE_REG;
      else if (mode_q == MODE_REG && capture_q == ExitWord)     mode_d = MODE_CNV;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_en_q     <= 1'b0;
      hold_valid_q   <= 1'b0;
      hold_data_q    <= '0;
      hold_snap_q    <= 1'b0;
      shift_q        <= '0;
      edge_cnt_q     <= '0;
      capture_q      <= '0;
      mode_q         <= MODE_CNV;
      underrun_count <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      frame_error <= drop_word | bad_frame;
      mode_q      <= mode_d;

      if (conv_frame) begin
        if (hold_snap_q)                    hold_valid_q   <= 1'b0;
        else if (underrun_count != 8'hFF)   underrun_count <= underrun_count + 8'd1;
      end
      if (s_hs) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= s_axis_tdata;
      end

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (reg_frame && !out_busy) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {8'h00, capture_q};
      end

      if (frame_start) begin
        edge_cnt_q  <= '0;
        capture_q   <= '0;
        hold_snap_q <= hold_valid_q;
        shift_q     <= (mode_q == MODE_CNV && hold_valid_q) ? hold_data_q : '0;
      end else if (state_q == ACTIVE) begin
        if (sck_rise) begin
          if (edge_cnt_q != EdgeMax) edge_cnt_q <= edge_cnt_q + 6'd1;
          capture_q <= {capture_q[22:0], sdo_level};
        end
        if (sck_fall && mode_q == MODE_CNV) shift_q <= shift_q << NUM_SDI;
      end
    end
  end

  assign s_axis_tready = ready_en_q & ~hold_valid_q;
  assign reg_mode      = (mode_q == MODE_REG);
  assign spi_sdi       = (state_q == ACTIVE && mode_q == MODE_CNV && !csn_level)
                         ? shift_q[31 -: NUM_SDI] : '0;

endmodule

// File: tb/tb_axis_exp_adc_responder.sv
// Bench for axis_exp_adc_responder: directed table, hand sequences for
// back-pressure/underrun saturation/reset, then randomized frames vs a frame-level model.
module tb_axis_exp_adc_responder;

  localparam int unsigned NSDI = 4;
  localparam int unsigned HALF = 6;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            spi_csn = 1'b1;
  logic            spi_sck = 1'b0;
  logic            spi_sdo = 1'b0;
  logic [NSDI-1:0] spi_sdi;
  logic [31:0]     s_axis_tdata = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [31:0]     m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready = 1'b1;
  logic            reg_mode;
  logic [7:0]      underrun_count;
  logic            frame_error;

  axis_exp_adc_responder #(.NUM_SDI(NSDI), .ExitWord(24'h801401)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .spi_csn(spi_csn), .spi_sck(spi_sck), .spi_sdo(spi_sdo), .spi_sdi(spi_sdi),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .reg_mode(reg_mode), .underrun_count(underrun_count), .frame_error(frame_error)
  );

  always #5 aclk = ~aclk;

  int          vectors = 0;
  int          miscompares = 0;
  int          ferr_cnt = 0;
  logic [31:0] got_q[$];

  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    if (frame_error) ferr_cnt++;
  end

  // Frame-level reference model
  bit          mdl_hold_v = 1'b0;
  logic [31:0] mdl_hold_d = '0;
  bit          mdl_reg = 1'b0;
  int          mdl_under = 0;
  bit          mdl_out_busy = 1'b0;
  logic [31:0] mdl_out_word = '0;
  int          mdl_ferr = 0;
  logic [31:0] exp_m_q[$];

  typedef struct {
    int unsigned n;
    logic [23:0] word;
    bit          push;
    logic [31:0] sample;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_tready;
    bit          exp_mode;
    logic [7:0]  exp_under;
    int          exp_ferr;
    bit          exp_m;
    logic [31:0] exp_mdata;
  } vec_t;

  vec_t tbl[10];

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_sample(input logic [31:0] d);
    int unsigned k;
    k = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && k < 100) begin
      @(negedge aclk);
      k++;
    end
    chk("push_ready", 32'(s_axis_tready), 32'd1);
    step();
    s_axis_tvalid = 1'b0;
    mdl_hold_v = 1'b1;
    mdl_hold_d = d;
  endtask

  task automatic spi_frame(input int unsigned nedges, input logic [23:0] word,
                           output logic [31:0] rd);
    rd = '0;
    spi_csn = 1'b0;
    step(8);
    for (int unsigned i = 0; i < nedges; i++) begin
      spi_sdo = word[23 - (i % 24)];
      step(HALF);
      rd = (rd << NSDI) | 32'(spi_sdi);
      spi_sck = 1'b1;
      step(HALF);
      spi_sck = 1'b0;
    end
    step(HALF);
    spi_csn = 1'b1;
    spi_sdo = 1'b0;
    step(8);
  endtask

  task automatic model_frame(input int unsigned n, input logic [23:0] word,
                             output logic [31:0] exp_rd);
    exp_rd = (!mdl_reg && mdl_hold_v) ? mdl_hold_d : 32'h0;
    if (n == 24) begin
      if (mdl_out_busy) mdl_ferr++;
      else if (m_axis_tready) exp_m_q.push_back({8'h00, word});
      else begin
        mdl_out_busy = 1'b1;
        mdl_out_word = {8'h00, word};
      end
      if (word[23:21] == 3'b101) mdl_reg = 1'b1;
      else if (mdl_reg && word == 24'h801401) mdl_reg = 1'b0;
    end else if (n == 32 / NSDI && !mdl_reg) begin
      if (mdl_hold_v) mdl_hold_v = 1'b0;
      else if (mdl_under < 255) mdl_under++;
    end else begin
      mdl_ferr++;
    end
  endtask

  task automatic run_frame(input string tag, input int unsigned n, input logic [23:0] word,
                           input bit chk_rd);
    logic [31:0] rd, exp_rd;
    got_q.delete();
    model_frame(n, word, exp_rd);
    spi_frame(n, word, rd);
    if (chk_rd) chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_mode"}, 32'(reg_mode), 32'(mdl_reg));
    chk({tag, "_under"}, 32'(underrun_count), 32'(mdl_under));
    chk({tag, "_ferr"}, 32'(ferr_cnt), 32'(mdl_ferr));
    chk({tag, "_mcount"}, 32'(got_q.size()), 32'(exp_m_q.size()));
    if (got_q.size() > 0 && exp_m_q.size() > 0) chk({tag, "_mdata"}, got_q[0], exp_m_q[0]);
    got_q.delete();
    exp_m_q.delete();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, dummy;
    int unsigned kind, sel, n;
    logic [23:0] w;

    tbl[0] = '{8,  24'h0,      1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0, 8'd0, 0, 0, 32'h0};
    tbl[1] = '{8,  24'h0,      0, 32'h0,        1, 32'h0,        1, 0, 8'd1, 0, 0, 32'h0};
    tbl[2] = '{24, 24'hA00000, 0, 32'h0,        0, 32'h0,        1, 1, 8'd1, 0, 1, 32'h00A00000};
    tbl[3] = '{24, 24'h801401, 0, 32'h0,        0, 32'h0,        1, 0, 8'd1, 0, 1, 32'h00801401};
    tbl[4] = '{24, 24'h123456, 0, 32'h0,        0, 32'h0,        1, 0, 8'd1, 0, 1, 32'h00123456};
    tbl[5] = '{5,  24'h0,      1, 32'h13579BDF, 0, 32'h0,        0, 0, 8'd1, 1, 0, 32'h0};
    tbl[6] = '{8,  24'h0,      0, 32'h0,        1, 32'h13579BDF, 1, 0, 8'd1, 1, 0, 32'h0};
    tbl[7] = '{24, 24'hB00000, 0, 32'h0,        0, 32'h0,        1, 1, 8'd1, 1, 1, 32'h00B00000};
    tbl[8] = '{8,  24'h0,      0, 32'h0,        1, 32'h0,        1, 1, 8'd1, 2, 0, 32'h0};
    tbl[9] = '{24, 24'h801401, 0, 32'h0,        0, 32'h0,        1, 0, 8'd1, 2, 1, 32'h00801401};

    // Reset state
    step(3);
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_sdi", 32'(spi_sdi), 32'd0);
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mode", 32'(reg_mode), 32'd0);
    aresetn = 1'b1;
    step(2);
    chk("post_rst_tready", 32'(s_axis_tready), 32'd1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].push) push_sample(tbl[i].sample);
      got_q.delete();
      model_frame(tbl[i].n, tbl[i].word, dummy);
      exp_m_q.delete();
      spi_frame(tbl[i].n, tbl[i].word, rd);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_tready", i), 32'(s_axis_tready), 32'(tbl[i].exp_tready));
      chk($sformatf("tbl%0d_mode", i), 32'(reg_mode), 32'(tbl[i].exp_mode));
      chk($sformatf("tbl%0d_under", i), 32'(underrun_count), 32'(tbl[i].exp_under));
      chk($sformatf("tbl%0d_ferr", i), 32'(ferr_cnt), 32'(tbl[i].exp_ferr));
      chk($sformatf("tbl%0d_mcount", i), 32'(got_q.size()), 32'(tbl[i].exp_m));
      if (tbl[i].exp_m && got_q.size() > 0)
        chk($sformatf("tbl%0d_mdata", i), got_q[0], tbl[i].exp_mdata);
    end

    // Back-pressure: first word held, second dropped
    m_axis_tready = 1'b0;
    run_frame("bp1", 24, 24'h111111, 0);
    run_frame("bp2", 24, 24'h222222, 0);
    chk("bp_mvalid", 32'(m_axis_tvalid), 32'd1);
    chk("bp_mdata", m_axis_tdata, 32'h00111111);
    got_q.delete();
    m_axis_tready = 1'b1;
    exp_m_q.push_back(mdl_out_word);
    mdl_out_busy = 1'b0;
    step(2);
    chk("bp_release_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("bp_release_data", got_q[0], exp_m_q[0]);
    chk("bp_release_mvalid", 32'(m_axis_tvalid), 32'd0);
    got_q.delete();
    exp_m_q.delete();

    // Underrun saturation
    for (int i = 0; i < 300; i++) begin
      model_frame(8, 24'h0, dummy);
      spi_frame(8, 24'h0, rd);
    end
    chk("sat_rd", rd, 32'h0);
    chk("sat_under", 32'(underrun_count), 32'd255);
    chk("sat_model_under", 32'(underrun_count), 32'(mdl_under));

    // Reset mid-frame
    run_frame("pre_rst_reg", 24, 24'hA12345, 0);
    push_sample(32'hCAFEF00D);
    spi_csn = 1'b0;
    step(8);
    repeat (3) begin
      step(HALF);
      spi_sck = 1'b1;
      step(HALF);
      spi_sck = 1'b0;
    end
    step(2);
    aresetn = 1'b0;
    step(2);
    chk("mid_rst_sdi", 32'(spi_sdi), 32'd0);
    chk("mid_rst_tready", 32'(s_axis_tready), 32'd0);
    chk("mid_rst_mdata", m_axis_tdata, 32'h0);
    chk("mid_rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_mode", 32'(reg_mode), 32'd0);
    chk("mid_rst_under", 32'(underrun_count), 32'd0);
    chk("mid_rst_ferr", 32'(frame_error), 32'd0);
    spi_csn = 1'b1;
    spi_sck = 1'b0;
    step(4);
    aresetn = 1'b1;
    step(2);
    mdl_hold_v = 1'b0;
    mdl_reg = 1'b0;
    mdl_under = 0;
    mdl_out_busy = 1'b0;
    got_q.delete();
    exp_m_q.delete();
    chk("after_rst_tready", 32'(s_axis_tready), 32'd1);
    push_sample(32'h0BADF00D);
    run_frame("after_rst", 8, 24'h0, 1);

    // Randomized frames
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      w = 24'($urandom);
      if (!mdl_hold_v && $urandom_range(0, 9) < 6) push_sample($urandom);
      if (kind < 5) begin
        n = 8;
      end else if (kind < 8) begin
        n = 24;
        sel = $urandom_range(0, 3);
        if (sel == 0) w[23:21] = 3'b101;
        else if (sel == 1) w = 24'h801401;
      end else begin
        n = $urandom_range(1, 30);
        while (n == 8 || n == 24) n = $urandom_range(1, 30);
      end
      run_frame($sformatf("rnd%0d", it), n, w, n == 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
